// File: rtl/selector_campo_edicion.sv
// Edit-mode front end: debounces four push-buttons, tracks the field being edited
// inside the selected group and drives the shared field code plus up/down levels.
module selector_campo_edicion #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [1:0] prog_sel,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic [1:0] field_idx
);

  localparam int             CW       = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam int             B_LEFT   = 0;
  localparam int             B_RIGHT  = 1;
  localparam int             B_UP     = 2;
  localparam int             B_DOWN   = 3;

  typedef enum logic [1:0] {
    GRP_NONE  = 2'b00,
    GRP_CLOCK = 2'b01,
    GRP_DATE  = 2'b10,
    GRP_TIMER = 2'b11
  } grp_e;

  function automatic logic [3:0] group_base(input grp_e grp);
    case (grp)
      GRP_CLOCK: group_base = 4'd1;
      GRP_DATE:  group_base = 4'd4;
      GRP_TIMER: group_base = 4'd10;
      default:   group_base = 4'd0;
    endcase
  endfunction

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d, deb_prev_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    rise;
  logic [1:0]    prog_sel_q;
  logic [1:0]    field_idx_q, field_idx_d;
  logic [3:0]    en_count_q, en_count_d;
  logic          en_up_q, en_up_d, en_down_q, en_down_d;
  grp_e          grp;

  assign raw  = {btn_down, btn_up, btn_right, btn_left};
  assign rise = deb_q & ~deb_prev_q;
  assign grp  = grp_e'(prog_sel);

  // Counter restarts whenever the synced input agrees with the accepted level.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    for (int i = 0; i < 4; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = ~deb_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    field_idx_d = field_idx_q;
    if (grp == GRP_NONE || prog_sel_q != prog_sel) begin
      field_idx_d = 2'd0;
    end else if (rise[B_RIGHT] && !rise[B_LEFT]) begin
      field_idx_d = (field_idx_q == 2'd2) ? 2'd0 : field_idx_q + 2'd1;
    end else if (rise[B_LEFT] && !rise[B_RIGHT]) begin
      field_idx_d = (field_idx_q == 2'd0) ? 2'd2 : field_idx_q - 2'd1;
    end
    en_count_d = group_base(grp) + {2'b00, field_idx_d};
    en_up_d    = deb_q[B_UP]   & ~deb_q[B_DOWN] & (grp != GRP_NONE);
    en_down_d  = deb_q[B_DOWN] & ~deb_q[B_UP]   & (grp != GRP_NONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      prog_sel_q  <= 2'b00;
      field_idx_q <= 2'd0;
      en_count_q  <= 4'd0;
      en_up_q     <= 1'b0;
      en_down_q   <= 1'b0;
      // NOTE: the counter array is small register state, so it is cleared like any other flop.
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      prog_sel_q  <= prog_sel;
      field_idx_q <= field_idx_d;
      en_count_q  <= en_count_d;
      en_up_q     <= en_up_d;
      en_down_q   <= en_down_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign en_count  = en_count_q;
  assign enUP      = en_up_q;
  assign enDOWN    = en_down_q;
  assign field_idx = field_idx_q;

endmodule
